t05_htree_sram_arbiter: RTL and testbench

- Shares the single h-tree SRAM port between three requesters: r0 h-tree builder (writes), r1 codebook synthesis (reads `h_element` by `curr_index`), r2 header/translate stage (reads).
- Sequences each access as grant, bus cycle, then completion. The completion pulse is the `SRAM_enable`-style "data stable" strobe that stage FSMs wait on.
- Sits between the stage FSMs and the SRAM/Wishbone adapter.

---
 rtl/t05_htree_sram_arbiter_pkg.sv | 30 +++
 rtl/t05_htree_sram_arbiter_rr_pick3.sv | 44 ++++
 rtl/t05_htree_sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_t05_htree_sram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_htree_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t05_arb_pkg
// Brief    : Shared types and constants for the h-tree SRAM arbiter.
// Revision : 1.0
// ============================================================================
package t05_arb_pkg;

  localparam int ARB_AW = 8;
  localparam int ARB_DW = 71;

  // Top-level stage codes, shared with the stage controller
  localparam logic [3:0] STAGE_HTREE = 4'd3;
  localparam logic [3:0] STAGE_CB    = 4'd4;
  localparam logic [3:0] STAGE_HDR   = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  function automatic logic [1:0] oh3_to_idx(input logic [2:0] oh);
    if (oh[2])      return 2'd2;
    else if (oh[1]) return 2'd1;
    else            return 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/t05_htree_sram_arbiter_rr_pick3.sv
`default_nettype none
// ============================================================================
// Module   : t05_rr_pick3
// Brief    : Combinational 3-way round-robin pick starting at i_ptr.
// Revision : 1.0
// ============================================================================
module t05_rr_pick3 (
  input  logic [2:0] i_elig,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_sel,
  output logic       o_valid
);

  logic [2:0] w_rot;
  logic [2:0] w_rsel;

  // Rotate so the highest-priority requester sits at bit 0
  always_comb begin
    case (i_ptr)
      2'd1:    w_rot = {i_elig[0], i_elig[2], i_elig[1]};
      2'd2:    w_rot = {i_elig[1], i_elig[0], i_elig[2]};
      default: w_rot = i_elig;
    endcase
  end

  always_comb begin
    if (w_rot[0])      w_rsel = 3'b001;
    else if (w_rot[1]) w_rsel = 3'b010;
    else if (w_rot[2]) w_rsel = 3'b100;
    else               w_rsel = 3'b000;
  end

  always_comb begin
    case (i_ptr)
      2'd1:    o_sel = {w_rsel[1], w_rsel[0], w_rsel[2]};
      2'd2:    o_sel = {w_rsel[0], w_rsel[2], w_rsel[1]};
      default: o_sel = w_rsel;
    endcase
  end

  assign o_valid = |i_elig;

endmodule
`default_nettype wire

// File: rtl/t05_htree_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t05_htree_sram_arbiter
// Brief    : Grant/bus/done sequencer sharing the h-tree SRAM port by 3 stages.
// Revision : 1.0
// ============================================================================
module t05_htree_sram_arbiter
  import t05_arb_pkg::*;
#(
  parameter int         AW       = ARB_AW,
  parameter int         DW       = ARB_DW,
  parameter int         NREQ     = 3,
  parameter int         TIMEOUT  = 32,
  parameter logic [3:0] STAGE_R0 = STAGE_HTREE,
  parameter logic [3:0] STAGE_R1 = STAGE_CB,
  parameter logic [3:0] STAGE_R2 = STAGE_HDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         i_en_state,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_req_we,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic [DW-1:0]      o_rdata,
  output logic               o_err,
  output logic               o_busy,
  output logic               o_timeout_sticky,
  output logic               o_sram_cyc,
  output logic               o_sram_we,
  output logic [AW-1:0]      o_sram_addr,
  output logic [DW-1:0]      o_sram_wdata,
  input  logic [DW-1:0]      i_sram_rdata,
  input  logic               i_sram_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_owner;
  logic [TW-1:0]    r_timer;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic             r_cyc;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [DW-1:0]    r_rdata;
  logic             r_err;
  logic             r_sticky;

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_sel;
  logic             w_valid;
  logic [1:0]       w_pick;
  logic             w_timer_max;
  logic [NREQ-1:0]  w_owner_oh;

  assign w_elig = {i_req[2] & (i_en_state == STAGE_R2),
                   i_req[1] & (i_en_state == STAGE_R1),
                   i_req[0] & (i_en_state == STAGE_R0)};

  t05_rr_pick3 u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_sel   (w_sel),
    .o_valid (w_valid)
  );

  assign w_pick      = oh3_to_idx(w_sel);
  assign w_timer_max = (r_timer == TW'(TIMEOUT - 1));
  assign w_owner_oh  = NREQ'(1) << r_owner;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_valid) w_state_nxt = ST_BUS;
      ST_BUS:  if (i_sram_ack || w_timer_max) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 2'd0;
      r_owner  <= 2'd0;
      r_timer  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cyc    <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_valid) begin
            r_owner <= w_pick;
            r_we    <= i_req_we[w_pick];
            r_addr  <= i_req_addr[w_pick*AW +: AW];
            r_wdata <= i_req_wdata[w_pick*DW +: DW];
            r_gnt   <= w_sel;
            r_cyc   <= 1'b1;
          end
        end
        ST_BUS: begin
          r_timer <= r_timer + TW'(1);
          // A late ack in the final timeout cycle still counts as success
          if (i_sram_ack) begin
            r_cyc   <= 1'b0;
            r_rdata <= r_we ? '0 : i_sram_rdata;
            r_err   <= 1'b0;
            r_done  <= w_owner_oh;
          end else if (w_timer_max) begin
            r_cyc    <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b1;
            r_sticky <= 1'b1;
            r_done   <= w_owner_oh;
          end
        end
        ST_DONE: begin
          r_rdata  <= '0;
          r_err    <= 1'b0;
          r_timer  <= '0;
          r_rr_ptr <= (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_gnt            = r_gnt;
  assign o_done           = r_done;
  assign o_rdata          = r_rdata;
  assign o_err            = r_err;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_timeout_sticky = r_sticky;
  assign o_sram_cyc       = r_cyc;
  assign o_sram_we        = r_we;
  assign o_sram_addr      = r_addr;
  assign o_sram_wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_t05_htree_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_t05_htree_sram_arbiter
// Brief    : Self-checking bench with SRAM slave model and scoreboard memory.
// Revision : 1.0
// ============================================================================
module tb_t05_htree_sram_arbiter;

  localparam int         AW  = 8;
  localparam int         DW  = 71;
  localparam int         TMO = 32;
  localparam logic [3:0] S0  = 4'd3;
  localparam logic [3:0] S1  = 4'd4;
  localparam logic [3:0] S2  = 4'd3;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]    en_state;
  logic [2:0]    req, req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]    gnt, done;
  logic [DW-1:0] rdata;
  logic          err, busy, sticky, cyc, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, sram_rdata;
  logic          sram_ack;

  int checks = 0;
  int errors = 0;
  int exp_ptr;
  bit exp_sticky;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int ack_lat;
  bit ack_en, stray;
  int cnt;

  always #5 clk = ~clk;

  t05_htree_sram_arbiter #(
    .AW(AW), .DW(DW), .NREQ(3), .TIMEOUT(TMO),
    .STAGE_R0(S0), .STAGE_R1(S1), .STAGE_R2(S2)
  ) dut (
    .clk(clk), .rst(rst), .i_en_state(en_state), .i_req(req), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_gnt(gnt), .o_done(done),
    .o_rdata(rdata), .o_err(err), .o_busy(busy), .o_timeout_sticky(sticky),
    .o_sram_cyc(cyc), .o_sram_we(we), .o_sram_addr(addr), .o_sram_wdata(wdata),
    .i_sram_rdata(sram_rdata), .i_sram_ack(sram_ack)
  );

  function automatic logic [DW-1:0] rnd71();
    return 71'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [3:0] stage_of(input int i);
    return (i == 0) ? S0 : ((i == 1) ? S1 : S2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SRAM slave: ack ack_lat cycles after cyc rises; write data lands in mem
  initial begin
    sram_ack = 1'b0;
    sram_rdata = '0;
    cnt = 0;
    forever begin
      step();
      sram_ack = 1'b0;
      if (cyc === 1'b1) begin
        if (ack_en && cnt == ack_lat) begin
          sram_ack = 1'b1;
          if (we) begin
            mem[addr] = wdata;
            sram_rdata = rnd71();
          end else begin
            sram_rdata = mem[addr];
          end
        end
        cnt++;
      end else begin
        cnt = 0;
        if (stray) begin
          sram_ack = 1'b1;
          sram_rdata = rnd71();
        end
      end
    end
  end

  task automatic do_access(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int lat, input bit wiggle);
    logic [2:0] oh;
    logic [2:0] exp_g;
    logic [DW-1:0] exp_rd;
    int nbus;
    bit tmo;
    oh = 3'b001 << i;
    tmo = (lat == 0);
    nbus = tmo ? TMO : lat + 1;
    ack_en = !tmo;
    ack_lat = lat;
    en_state = stage_of(i);
    req_we[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    for (int k = 1; k <= nbus; k++) begin
      step();
      exp_g = (k == 1) ? oh : 3'b000;
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL gnt r%0d cyc%0d: got %b exp %b", i, k, gnt, exp_g);
      end
      checks++;
      if ({cyc, we, addr, wdata, done, busy} !== {1'b1, w, a, d, 3'b000, 1'b1}) begin
        errors++;
        $display("FAIL bus_hold r%0d cyc%0d: got cyc=%b we=%b addr=%h wdata=%h done=%b busy=%b exp cyc=1 we=%b addr=%h wdata=%h done=000 busy=1",
                 i, k, cyc, we, addr, wdata, done, busy, w, a, d);
      end
      if (wiggle) begin
        if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
        en_state = 4'($urandom_range(15, 0));
      end
    end
    step();
    exp_rd = (tmo || w) ? '0 : ref_mem[a];
    if (!tmo && w) ref_mem[a] = d;
    exp_sticky = exp_sticky | tmo;
    checks++;
    if ({done, cyc, err, rdata, sticky} !== {oh, 1'b0, tmo, exp_rd, exp_sticky}) begin
      errors++;
      $display("FAIL done r%0d: got done=%b cyc=%b err=%b rdata=%h sticky=%b exp done=%b cyc=0 err=%b rdata=%h sticky=%b",
               i, done, cyc, err, rdata, sticky, oh, tmo, exp_rd, exp_sticky);
    end
    exp_ptr = (i + 1) % 3;
    req[i] = 1'b0;
    step();
    checks++;
    if ({busy, done, cyc} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after r%0d: got busy=%b done=%b cyc=%b exp 0", i, busy, done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({gnt, done, rdata, err, busy, sticky, cyc, we, addr, wdata} !== '0) begin
      errors++;
      $display("FAIL reset: got gnt=%b done=%b rdata=%h err=%b busy=%b sticky=%b cyc=%b we=%b addr=%h wdata=%h exp all 0",
               gnt, done, rdata, err, busy, sticky, cyc, we, addr, wdata);
    end
    rst = 1'b0;
    exp_ptr = 0;
    exp_sticky = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    mem[8'h1F] = 71'h5A;
    ref_mem[8'h1F] = 71'h5A;
    do_access(1, 1'b0, 8'h1F, '0, 2, 1'b0);
  endtask

  task automatic test_write_readback();
    do_access(0, 1'b1, 8'h07, 71'h1_2345, 2, 1'b0);
    do_access(1, 1'b0, 8'h07, '0, 3, 1'b0);
  endtask

  task automatic test_stage_gating();
    bit seen;
    en_state = S0;
    ack_en = 1'b1;
    ack_lat = 1;
    req_we[1] = 1'b0;
    req_addr[AW +: AW] = 8'h3C;
    req[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({gnt, busy} !== 4'b0) begin
        errors++;
        $display("FAIL gating cyc%0d: got gnt=%b busy=%b exp 0", k, gnt, busy);
      end
    end
    en_state = S1;
    step();
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL gating_release: got gnt=%b exp 010", gnt);
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (done !== 3'b000);
    end
    checks++;
    if (!seen || done !== 3'b010 || rdata !== ref_mem[8'h3C]) begin
      errors++;
      $display("FAIL gating_done: got done=%b rdata=%h exp done=010 rdata=%h", done, rdata, ref_mem[8'h3C]);
    end
    exp_ptr = 2;
    req[1] = 1'b0;
    step();
  endtask

  task automatic test_random_access();
    for (int n = 0; n < 12; n++) begin
      do_access($urandom_range(2, 0), 1'($urandom_range(1, 0)),
                8'h80 + 8'($urandom_range(7, 0)), rnd71(), $urandom_range(6, 1), 1'b1);
    end
  endtask

  task automatic test_round_robin();
    int got [3];
    int steps;
    int exp_i;
    logic [2:0] elig;
    logic [2:0] oh;
    logic [AW-1:0] a;
    bit seen;
    got = '{0, 0, 0};
    en_state = S0;
    ack_en = 1'b1;
    req_we = 3'b000;
    req_addr[0 +: AW] = 8'h21;
    req_addr[2*AW +: AW] = 8'hC4;
    req = 3'b101;
    for (int n = 0; n < 20; n++) begin
      ack_lat = $urandom_range(4, 1);
      for (int j = 0; j < 3; j++) elig[j] = (j != 1) && (en_state == stage_of(j));
      exp_i = -1;
      for (int k = 2; k >= 0; k--) if (elig[(exp_ptr + k) % 3]) exp_i = (exp_ptr + k) % 3;
      oh = 3'b001 << exp_i;
      seen = 1'b0;
      steps = 0;
      for (int w = 0; w < 6 && !seen; w++) begin
        req[1] = 1'($urandom_range(1, 0));
        step();
        steps++;
        seen = (gnt !== 3'b000);
      end
      checks++;
      if (!seen || gnt !== oh || steps != ((n == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL rr_gnt n%0d: got gnt=%b after %0d cycles exp gnt=%b after %0d", n, gnt, steps, oh, (n == 0) ? 1 : 2);
      end
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        step();
        seen = (done !== 3'b000);
      end
      a = (exp_i == 0) ? 8'h21 : 8'hC4;
      checks++;
      if (!seen || done !== oh || err !== 1'b0 || rdata !== ref_mem[a]) begin
        errors++;
        $display("FAIL rr_done n%0d: got done=%b err=%b rdata=%h exp done=%b err=0 rdata=%h", n, done, err, rdata, oh, ref_mem[a]);
      end
      if (exp_i >= 0) got[exp_i]++;
      exp_ptr = (exp_i + 1) % 3;
    end
    req = 3'b000;
    step();
    checks++;
    if (got[0] != 10 || got[2] != 10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_fair: got r0=%0d r2=%0d busy=%b exp r0=10 r2=10 busy=0", got[0], got[2], busy);
    end
  endtask

  task automatic test_timeout();
    do_access(1, 1'b0, 8'h55, '0, TMO - 1, 1'b0);
    do_access(1, 1'b0, 8'h66, '0, 0, 1'b0);
    do_access(0, 1'b1, 8'h77, rnd71(), 3, 1'b0);
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_bus();
    ack_en = 1'b0;
    en_state = S1;
    req_we[1] = 1'b0;
    req_addr[AW +: AW] = 8'h10;
    req[1] = 1'b1;
    step();
    checks++;
    if ({gnt, cyc} !== 4'b0101) begin
      errors++;
      $display("FAIL rst_bus_start: got gnt=%b cyc=%b exp gnt=010 cyc=1", gnt, cyc);
    end
    step();
    step();
    rst = 1'b1;
    req = 3'b000;
    step();
    checks++;
    if ({gnt, done, rdata, err, busy, sticky, cyc, we, addr, wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_bus: got gnt=%b done=%b rdata=%h err=%b busy=%b sticky=%b cyc=%b we=%b addr=%h exp all 0",
               gnt, done, rdata, err, busy, sticky, cyc, we, addr);
    end
    rst = 1'b0;
    exp_ptr = 0;
    exp_sticky = 1'b0;
    stray = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({done, busy, cyc, err} !== 6'b0) begin
        errors++;
        $display("FAIL stray_ack cyc%0d: got done=%b busy=%b cyc=%b err=%b exp 0", k, done, busy, cyc, err);
      end
    end
    stray = 1'b0;
    ack_en = 1'b1;
    do_access(2, 1'b0, 8'h82, '0, 1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    en_state = 4'd0;
    req = 3'b000;
    req_we = 3'b000;
    req_addr = '0;
    req_wdata = '0;
    ack_en = 1'b1;
    ack_lat = 1;
    stray = 1'b0;
    exp_ptr = 0;
    exp_sticky = 1'b0;
    for (int k = 0; k < 256; k++) begin
      mem[k] = rnd71();
      ref_mem[k] = mem[k];
    end
    test_reset();
    test_single_read();
    test_write_readback();
    test_stage_gating();
    test_random_access();
    test_round_robin();
    test_timeout();
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish exp finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
